// File: rtl/morse_clock_divider.sv
// Programmable 50%-duty clock divider for the Morse LED sequencer time base.
// Produces a registered div_clk plus a one-cycle tick on each div_clk rise.
module morse_clock_divider #(
    parameter int HALF_PERIOD = 2500,
    parameter int CNT_W       = 32
) (
    input  logic             slow_clock,
    input  logic             reset,
    input  logic             en,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
    output logic             div_clk,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] HALF_INIT = CNT_W'(HALF_PERIOD);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_reg;

    // A zero half-period would never terminate a phase, so it is clamped to 1.
    always_ff @(posedge slow_clock) begin
        if (!reset) begin
            cnt      <= '0;
            half_reg <= HALF_INIT;
            div_clk  <= 1'b0;
            tick     <= 1'b0;
        end else if (div_load) begin
            half_reg <= (div_value == '0) ? ONE : div_value;
            cnt      <= '0;
            tick     <= 1'b0;
        end else if (en) begin
            if (cnt == half_reg - ONE) begin
                cnt     <= '0;
                div_clk <= ~div_clk;
                tick    <= ~div_clk;
            end else begin
                cnt     <= cnt + ONE;
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    assign count = cnt;

endmodule

// File: tb/tb_morse_clock_divider.sv
// Self-checking bench for morse_clock_divider: directed and randomized steps
// against an elapsed-cycle reference model, plus a default-ratio period check.
module tb_morse_clock_divider;

    localparam int HP = 4;

    logic        slow_clock;
    logic        reset;
    logic        en;
    logic        div_load;
    logic [31:0] div_value;
    logic        div_clk;
    logic        tick;
    logic [31:0] count;

    logic        reset2;
    logic        en2;
    logic        load2;
    logic [31:0] value2;
    logic        div_clk2;
    logic        tick2;
    logic [31:0] count2;

    int checks;
    int failures;
    int step;

    // Reference model: enabled edges since the last reset/load decide everything.
    longint elapsed;
    int     m_half;
    logic   m_base;
    logic   m_stepped;
    logic   m_clk;
    logic   m_tick;
    int     m_cnt;

    morse_clock_divider #(.HALF_PERIOD(HP), .CNT_W(32)) dut (
        .slow_clock(slow_clock),
        .reset(reset),
        .en(en),
        .div_load(div_load),
        .div_value(div_value),
        .div_clk(div_clk),
        .tick(tick),
        .count(count)
    );

    morse_clock_divider dut_default (
        .slow_clock(slow_clock),
        .reset(reset2),
        .en(en2),
        .div_load(load2),
        .div_value(value2),
        .div_clk(div_clk2),
        .tick(tick2),
        .count(count2)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    task automatic modelStep(input logic r, input logic e, input logic l, input logic [31:0] v);
        if (!r) begin
            elapsed   = 0;
            m_half    = HP;
            m_base    = 1'b0;
            m_stepped = 1'b0;
        end else if (l) begin
            m_half    = (v == 0) ? 1 : int'(v);
            m_base    = m_clk;
            elapsed   = 0;
            m_stepped = 1'b0;
        end else if (e) begin
            elapsed   = elapsed + 1;
            m_stepped = 1'b1;
        end else begin
            m_stepped = 1'b0;
        end
        m_clk  = m_base ^ logic'((elapsed / m_half) % 2);
        m_cnt  = int'(elapsed % m_half);
        m_tick = m_stepped && (m_cnt == 0) && m_clk;
    endtask

    task automatic checkValue(input string tag, input longint observed, input longint expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s step=%0d observed=%0d expected=%0d", tag, step, observed, expected);
        end
    endtask

    task automatic checkOutput();
        checkValue("div_clk", longint'(div_clk), longint'(m_clk));
        checkValue("tick", longint'(tick), longint'(m_tick));
        checkValue("count", longint'(count), longint'(m_cnt));
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic l, input logic [31:0] v);
        @(negedge slow_clock);
        reset     = r;
        en        = e;
        div_load  = l;
        div_value = v;
        @(posedge slow_clock);
        modelStep(r, e, l, v);
        step++;
        #1;
        checkOutput();
    endtask

    initial begin
        int wait_cycles;
        int high_cycles;
        int low_cycles;
        int tick_count;

        checks    = 0;
        failures  = 0;
        step      = 0;
        elapsed   = 0;
        m_half    = HP;
        m_base    = 1'b0;
        m_clk     = 1'b0;
        m_stepped = 1'b0;
        reset     = 1'b0;
        en        = 1'b0;
        div_load  = 1'b0;
        div_value = '0;
        reset2    = 1'b0;
        en2       = 1'b0;
        load2     = 1'b0;
        value2    = '0;

        // Reset, then free-run long enough to see rise at 4, fall at 8, rise at 12.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

        // Reach the high phase at cnt=2, freeze for 5 cycles, then resume.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkValue("mid_high_count", longint'(count), 64'd2);
        checkValue("mid_high_clk", longint'(div_clk), 64'd1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

        // Divide by two via explicit 1 and via clamped 0.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'd1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

        // Reset wins over a simultaneous load.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd7);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

        // Reset mid high phase at cnt=3, then the first rise is at the 4th enabled edge.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkValue("pre_reset_count", longint'(count), 64'd3);
        checkValue("pre_reset_clk", longint'(div_clk), 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkValue("before_fourth_clk", longint'(div_clk), 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkValue("fourth_edge_clk", longint'(div_clk), 64'd1);
        checkValue("fourth_edge_tick", longint'(tick), 64'd1);

        // Randomized mix of enable, reloads and occasional resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(logic'($urandom_range(0, 39) != 0),
                          logic'($urandom_range(0, 3) != 0),
                          logic'($urandom_range(0, 14) == 0),
                          32'($urandom_range(0, 6)));
        end

        // Default ratio: 2500 low, 2500 high, one tick per 5000-cycle period.
        @(negedge slow_clock);
        reset2 = 1'b0;
        en2    = 1'b1;
        @(negedge slow_clock);
        reset2 = 1'b1;
        wait_cycles = 0;
        do begin
            @(posedge slow_clock);
            #1;
            wait_cycles++;
        end while (!div_clk2 && wait_cycles < 6000);
        checkValue("default_first_rise", longint'(wait_cycles), 64'd2500);
        checkValue("default_first_tick", longint'(tick2), 64'd1);
        high_cycles = 0;
        tick_count  = 0;
        while (div_clk2 && high_cycles < 6000) begin
            @(posedge slow_clock);
            #1;
            high_cycles++;
            if (tick2) tick_count++;
        end
        low_cycles = 0;
        while (!div_clk2 && low_cycles < 6000) begin
            @(posedge slow_clock);
            #1;
            low_cycles++;
            if (tick2) tick_count++;
        end
        checkValue("default_high", longint'(high_cycles), 64'd2500);
        checkValue("default_period", longint'(high_cycles + low_cycles), 64'd5000);
        checkValue("default_ticks", longint'(tick_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
